// File: rtl/arya_debug_ctrl_if.sv
// Command/status bundle between the software command register (master) and
// the arya run/halt/step controller (slave).
// Breakpoint signals exist only when ARYA_DBG_BREAKPOINT_EN is defined.
interface arya_debug_ctrl_if #(
  parameter int unsigned STEP_WIDTH  = 3,
  parameter int unsigned COUNT_WIDTH = 32,
  parameter int unsigned PC_WIDTH    = 9
) ();

  // Software commands
  logic                   cpu_reset_req;
  logic                   debug_en;
  logic                   stepinto_en;
  logic [STEP_WIDTH-1:0]  stepvalue;
  logic                   cnt_clr;

  // Controller status / core controls
  logic                   cpu_en;
  logic                   cpu_reset;
  logic [COUNT_WIDTH-1:0] step_count;
  logic                   busy;
  logic                   step_done;

`ifdef ARYA_DBG_BREAKPOINT_EN
  logic [PC_WIDTH-1:0]    bp_pc;
  logic [PC_WIDTH-1:0]    bp_addr;
  logic                   bp_valid;
  logic                   bp_hit;

  modport master (
    output cpu_reset_req, debug_en, stepinto_en, stepvalue, cnt_clr,
    output bp_pc, bp_addr, bp_valid,
    input  cpu_en, cpu_reset, step_count, busy, step_done, bp_hit
  );

  modport slave (
    input  cpu_reset_req, debug_en, stepinto_en, stepvalue, cnt_clr,
    input  bp_pc, bp_addr, bp_valid,
    output cpu_en, cpu_reset, step_count, busy, step_done, bp_hit
  );
`else
  modport master (
    output cpu_reset_req, debug_en, stepinto_en, stepvalue, cnt_clr,
    input  cpu_en, cpu_reset, step_count, busy, step_done
  );

  modport slave (
    input  cpu_reset_req, debug_en, stepinto_en, stepvalue, cnt_clr,
    output cpu_en, cpu_reset, step_count, busy, step_done
  );
`endif

endinterface

// File: rtl/arya_debug_ctrl.sv
// arya_debug_ctrl: run/halt/single-step controller for the arya core.
// Gates the core clock-enable (free-run, halt, or a 1..2^STEP_WIDTH cycle
// step), drives the core reset from the software reset command, and counts
// enabled cycles for the step-count register. All outputs are registered.
// Optional PC breakpoint: define ARYA_DBG_BREAKPOINT_EN.
module arya_debug_ctrl #(
  parameter int unsigned STEP_WIDTH  = 3,
  parameter int unsigned COUNT_WIDTH = 32,
  parameter int unsigned PC_WIDTH    = 9
) (
  input  logic               clk,
  input  logic               reset,
  arya_debug_ctrl_if.slave   bus
);

  localparam int unsigned REM_WIDTH = STEP_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2,
    ST_RST  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [REM_WIDTH-1:0]   remaining_q, remaining_d;
  logic                   stepinto_q, stepinto_d;
  logic                   cpu_en_q, cpu_en_d;
  logic                   cpu_reset_q, cpu_reset_d;
  logic [COUNT_WIDTH-1:0] step_count_q, step_count_d;
  logic                   busy_q, busy_d;
  logic                   step_done_q, step_done_d;

  logic                   step_edge;
  logic                   bp_match;

  // Trigger acts on its rising edge only; the registered copy resets to 1 so a
  // trigger held high through reset does not fire.
  assign stepinto_d = bus.stepinto_en;
  assign step_edge  = bus.stepinto_en & ~stepinto_q;

`ifdef ARYA_DBG_BREAKPOINT_EN
  logic bp_hit_q, bp_hit_d;

  assign bp_match = bus.bp_valid && (bus.bp_pc == bus.bp_addr);
`else
  assign bp_match = 1'b0;
`endif

  // Next-state, step down-counter and registered-output values.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves a
    // value unassigned and no latch is inferred.
    state_d     = state_q;
    remaining_d = '0;
    step_done_d = 1'b0;

    if (bus.cpu_reset_req) begin
      // Core reset overrides everything, aborting any step without step_done.
      state_d = ST_RST;
    end else begin
      unique case (state_q)
        ST_RST: begin
          state_d = bus.debug_en ? ST_HALT : ST_RUN;
        end
        ST_RUN: begin
          // A breakpoint hit halts even in free-run mode.
          if (bp_match || bus.debug_en) begin
            state_d = ST_HALT;
          end
        end
        ST_HALT: begin
          // A persisting breakpoint match keeps the core halted.
          if (!bus.debug_en && !bp_match) begin
            state_d = ST_RUN;
          end else if (step_edge && !step_done_q) begin
            // The cycle carrying step_done cannot start the next step.
            state_d     = ST_STEP;
            remaining_d = {1'b0, bus.stepvalue} + REM_WIDTH'(1);
          end
        end
        ST_STEP: begin
          if (remaining_q == REM_WIDTH'(1)) begin
            state_d     = ST_HALT;
            step_done_d = 1'b1;
          end else if (!bus.debug_en) begin
            state_d = ST_RUN;
          end else begin
            remaining_d = remaining_q - REM_WIDTH'(1);
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end

    // Outputs follow the state being entered, so they are valid one cycle
    // after the inputs that caused the transition.
    cpu_en_d    = (state_d == ST_RUN) || (state_d == ST_STEP);
    cpu_reset_d = (state_d == ST_RST);
    busy_d      = (state_d == ST_STEP);

    // Count the cycles the core was actually enabled; clear wins.
    if (bus.cnt_clr || bus.cpu_reset_req) begin
      step_count_d = '0;
    end else begin
      step_count_d = step_count_q + COUNT_WIDTH'(cpu_en_q);
    end
  end

`ifdef ARYA_DBG_BREAKPOINT_EN
  // Sticky breakpoint flag: set on a RUN-to-HALT breakpoint halt, held until
  // the state leaves HALT.
  always_comb begin
    bp_hit_d = 1'b0;
    if (state_d == ST_HALT) begin
      bp_hit_d = bp_hit_q || ((state_q == ST_RUN) && bp_match);
    end
  end

  // Breakpoint flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      bp_hit_q <= 1'b0;
    end else begin
      bp_hit_q <= bp_hit_d;
    end
  end

  assign bus.bp_hit = bp_hit_q;
`endif

  // State and output registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q      <= ST_RUN;
      remaining_q  <= '0;
      stepinto_q   <= 1'b1;
      cpu_en_q     <= 1'b0;
      cpu_reset_q  <= 1'b0;
      step_count_q <= '0;
      busy_q       <= 1'b0;
      step_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      stepinto_q   <= stepinto_d;
      cpu_en_q     <= cpu_en_d;
      cpu_reset_q  <= cpu_reset_d;
      step_count_q <= step_count_d;
      busy_q       <= busy_d;
      step_done_q  <= step_done_d;
    end
  end

  assign bus.cpu_en     = cpu_en_q;
  assign bus.cpu_reset  = cpu_reset_q;
  assign bus.step_count = step_count_q;
  assign bus.busy       = busy_q;
  assign bus.step_done  = step_done_q;

endmodule

// File: tb/tb_arya_debug_ctrl.sv
// Self-checking bench for arya_debug_ctrl: directed scenarios followed by
// randomized command traffic, every cycle compared against a behavioural
// model of run/halt/step semantics. Define ARYA_DBG_BREAKPOINT_EN to also
// exercise the breakpoint.
module tb_arya_debug_ctrl;

  localparam int unsigned STEP_WIDTH  = 3;
  localparam int unsigned COUNT_WIDTH = 32;
  localparam int unsigned PC_WIDTH    = 9;

  logic clk = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_err    = 0;

  arya_debug_ctrl_if #(
    .STEP_WIDTH (STEP_WIDTH),
    .COUNT_WIDTH(COUNT_WIDTH),
    .PC_WIDTH   (PC_WIDTH)
  ) bus ();

  arya_debug_ctrl #(
    .STEP_WIDTH (STEP_WIDTH),
    .COUNT_WIDTH(COUNT_WIDTH),
    .PC_WIDTH   (PC_WIDTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: core in reset / halted / stepping (cycles left) / running.
  logic                   m_rst;
  logic                   m_halt;
  int                     m_left;
  logic                   m_en;
  logic                   m_done;
  logic                   m_hit;
  logic                   m_prev_trig;
  logic [COUNT_WIDTH-1:0] m_count;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic prev_en;
    logic done_prev;
    logic edge_seen;
    logic match;
    logic fired;
    if (reset) begin
      m_rst = 0; m_halt = 0; m_left = 0; m_en = 0; m_done = 0; m_hit = 0;
      m_prev_trig = 1; m_count = '0;
      return;
    end
    prev_en   = m_en;
    done_prev = m_done;
    m_done    = 0;
    fired     = 0;
    edge_seen = bus.stepinto_en && !m_prev_trig;
    m_prev_trig = bus.stepinto_en;
    match = 0;
`ifdef ARYA_DBG_BREAKPOINT_EN
    match = bus.bp_valid && (bus.bp_pc == bus.bp_addr);
`endif
    if (bus.cnt_clr || bus.cpu_reset_req) m_count = '0;
    else m_count = m_count + COUNT_WIDTH'(prev_en);

    if (bus.cpu_reset_req) begin
      m_rst = 1; m_halt = 0; m_left = 0;
    end else if (m_rst) begin
      m_rst = 0; m_halt = bus.debug_en;
    end else if (m_left > 0) begin
      if (m_left == 1) begin
        m_left = 0; m_halt = 1; m_done = 1;
      end else if (!bus.debug_en) begin
        m_left = 0; m_halt = 0;
      end else begin
        m_left = m_left - 1;
      end
    end else if (m_halt) begin
      if (!bus.debug_en && !match) m_halt = 0;
      else if (edge_seen && !done_prev) begin
        m_halt = 0; m_left = int'(bus.stepvalue) + 1;
      end
    end else begin
      if (match) begin
        m_halt = 1; fired = 1;
      end else if (bus.debug_en) begin
        m_halt = 1;
      end
    end
    m_en  = !m_rst && !m_halt;
    m_hit = (!m_rst && m_halt) ? (m_hit || fired) : 1'b0;
  endtask

  // One clock: advance the model at the edge, compare all outputs just after.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("cpu_en",     bus.cpu_en,     m_en);
    check("cpu_reset",  bus.cpu_reset,  m_rst);
    check("busy",       bus.busy,       m_left > 0);
    check("step_done",  bus.step_done,  m_done);
    check("step_count", bus.step_count, m_count);
`ifdef ARYA_DBG_BREAKPOINT_EN
    check("bp_hit",     bus.bp_hit,     m_hit);
`endif
  endtask

  initial begin
    int en_n;
    int busy_n;
    int done_n;
    logic [COUNT_WIDTH-1:0] c0;

    reset = 1;
    bus.cpu_reset_req = 0; bus.debug_en = 0; bus.stepinto_en = 0;
    bus.stepvalue = '0; bus.cnt_clr = 0;
`ifdef ARYA_DBG_BREAKPOINT_EN
    bus.bp_pc = '0; bus.bp_addr = '0; bus.bp_valid = 0;
`endif

    // Reset state, then free-run for 10 cycles.
    repeat (3) tick();
    check("rst_cpu_en", bus.cpu_en, 0);
    check("rst_count",  bus.step_count, 0);
    check("rst_busy",   bus.busy, 0);
    reset = 0;
    tick();
    check("run_en_c1", bus.cpu_en, 1);
    repeat (10) tick();
    check("run_cnt_c11", bus.step_count, 10);

    // Halt, then a 4-cycle step.
    bus.debug_en = 1;
    repeat (2) tick();
    check("halt_en", bus.cpu_en, 0);
    c0 = m_count;
    bus.stepvalue = 3; bus.stepinto_en = 1;
    tick();
    bus.stepinto_en = 0;
    en_n = 0; busy_n = 0; done_n = 0;
    for (int i = 0; i < 6; i++) begin
      en_n += int'(bus.cpu_en); busy_n += int'(bus.busy); done_n += int'(bus.step_done);
      tick();
    end
    check("step4_en_cycles",   en_n, 4);
    check("step4_busy_cycles", busy_n, 4);
    check("step4_done_pulses", done_n, 1);
    check("step4_count",       bus.step_count, c0 + 4);

    // 8-cycle step aborted by dropping debug_en after 2 enabled cycles.
    bus.stepvalue = 7; bus.stepinto_en = 1;
    tick();
    bus.stepinto_en = 0;
    tick();
    bus.debug_en = 0;
    tick();
    check("abort_en",   bus.cpu_en, 1);
    check("abort_busy", bus.busy, 0);
    en_n = 0; done_n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      en_n += int'(bus.cpu_en); done_n += int'(bus.step_done);
    end
    check("abort_run_en",  en_n, 4);
    check("abort_no_done", done_n, 0);

    // Trigger held high through reset must not fire; a fresh edge steps once.
    reset = 1; bus.stepinto_en = 1; bus.debug_en = 1;
    repeat (2) tick();
    reset = 0;
    repeat (3) tick();
    check("held_trig_en",   bus.cpu_en, 0);
    check("held_trig_busy", bus.busy, 0);
    bus.stepinto_en = 0; bus.stepvalue = 0;
    tick();
    bus.stepinto_en = 1;
    tick();
    bus.stepinto_en = 0;
    check("step1_en",   bus.cpu_en, 1);
    check("step1_busy", bus.busy, 1);
    tick();
    check("step1_off",  bus.cpu_en, 0);
    check("step1_done", bus.step_done, 1);

    // Core reset mid-step, then release into HALT; then cnt_clr in RUN.
    tick();
    bus.stepvalue = 5; bus.stepinto_en = 1;
    tick();
    bus.stepinto_en = 0;
    tick();
    bus.cpu_reset_req = 1;
    tick();
    check("creq_cpu_reset", bus.cpu_reset, 1);
    check("creq_cpu_en",    bus.cpu_en, 0);
    check("creq_count",     bus.step_count, 0);
    tick();
    bus.cpu_reset_req = 0;
    tick();
    check("crel_cpu_reset", bus.cpu_reset, 0);
    check("crel_halt_en",   bus.cpu_en, 0);
    done_n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      done_n += int'(bus.step_done);
    end
    check("creq_no_done", done_n, 0);
    bus.debug_en = 0;
    repeat (3) tick();
    bus.cnt_clr = 1;
    tick();
    check("clr_count", bus.step_count, 0);
    bus.cnt_clr = 0;
    tick();
    check("clr_then_count", bus.step_count, 1);

`ifdef ARYA_DBG_BREAKPOINT_EN
    // Breakpoint at 0x1F while the PC ramps in free-run, then step off it.
    bus.bp_addr = 9'h01F; bus.bp_valid = 1;
    for (int i = 0; i < 8; i++) begin
      bus.bp_pc = PC_WIDTH'(9'h018 + i);
      tick();
    end
    check("bp_halt_en", bus.cpu_en, 0);
    check("bp_hit_set", bus.bp_hit, 1);
    repeat (2) tick();
    check("bp_hold_en",  bus.cpu_en, 0);
    check("bp_hold_hit", bus.bp_hit, 1);
    bus.debug_en = 1; bus.stepvalue = 0; bus.stepinto_en = 1;
    tick();
    bus.stepinto_en = 0;
    check("bp_step_en",  bus.cpu_en, 1);
    check("bp_hit_clr",  bus.bp_hit, 0);
    bus.bp_pc = 9'h020;
    tick();
    bus.debug_en = 0;
    repeat (2) tick();
    check("bp_resume_en", bus.cpu_en, 1);
    bus.bp_valid = 0;
`endif

    // Randomized command traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset             = ($urandom_range(0, 299) == 0);
      bus.cpu_reset_req = ($urandom_range(0, 30) == 0);
      if ($urandom_range(0, 5) == 0) bus.debug_en = ~bus.debug_en;
      bus.stepinto_en   = ($urandom_range(0, 2) == 0);
      bus.stepvalue     = STEP_WIDTH'($urandom);
      bus.cnt_clr       = ($urandom_range(0, 39) == 0);
`ifdef ARYA_DBG_BREAKPOINT_EN
      bus.bp_valid      = ($urandom_range(0, 3) == 0);
      bus.bp_addr       = PC_WIDTH'($urandom_range(0, 3));
      bus.bp_pc         = PC_WIDTH'($urandom_range(0, 3));
`endif
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/arya_debug_ctrl.md
# arya_debug_ctrl

Run/halt/single-step controller for the arya core. It sits between the software command register and the core's `en`/`reset` inputs. It gates the core clock-enable so software can stop the core, advance it by 1–8 cycles, or let it run free. It also keeps the enabled-cycle count that software reads back as the step-count hardware register.

## Interface
Parameters:
- `STEP_WIDTH`, default 3: width of `stepvalue`.
- `COUNT_WIDTH`, default 32: width of `step_count`.
- `PC_WIDTH`, default 9: PC width (breakpoint only).

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `cpu_reset_req` in 1: software core-reset command, level.
- `debug_en` in 1: debug mode, level; 0 means free-run.
- `stepinto_en` in 1: step trigger; acts on its rising edge only.
- `stepvalue` in STEP_WIDTH: step length minus 1.
- `cnt_clr` in 1: clear `step_count`, level.
- `cpu_en` out 1: core clock-enable, registered.
- `cpu_reset` out 1: core reset, registered.
- `step_count` out COUNT_WIDTH: number of cycles with `cpu_en`=1.
- `busy` out 1: high while a step is in progress.
- `step_done` out 1: one-cycle pulse when a step completes.
- `bp_pc` in PC_WIDTH: core PC (breakpoint only).
- `bp_addr` in PC_WIDTH: breakpoint address (breakpoint only).
- `bp_valid` in 1: breakpoint armed (breakpoint only).
- `bp_hit` out 1: sticky breakpoint-halt flag (breakpoint only).

## Operation
States: RUN, HALT, STEP, RST. `remaining` is a STEP_WIDTH+1 down-counter.

Transitions (evaluated in priority order):
- `cpu_reset_req`=1 in any state → RST. It overrides everything, including a step in progress; that step is aborted with no `step_done`.
- RST while `cpu_reset_req`=1: `cpu_reset`=1, `cpu_en`=0.
- RST on release: → HALT if `debug_en`=1, otherwise → RUN.
- RUN: `cpu_en`=1. `debug_en`=1 → HALT.
- HALT: `cpu_en`=0.
  - `debug_en`=0 → RUN.
  - Otherwise, a `stepinto_en` rising edge → STEP, with `remaining` = `stepvalue`+1 (range 1..8).
- STEP: `cpu_en`=1, `busy`=1, and `remaining` decrements each cycle.
  - When `remaining`==1 → HALT, and `step_done` pulses on the cycle `cpu_en` returns low.
  - `debug_en` dropping mid-step → RUN immediately; remaining cycles are dropped and there is no `step_done`.

Edge detection:
- `stepinto_en` is edge-detected against a registered copy, and the copy resets to 1. A trigger held high through reset therefore does not fire.
- Edges arriving in RUN, STEP or RST are ignored and never queued.

Step counter:
- `step_count` increments on every cycle where `cpu_en`=1 and wraps modulo 2^COUNT_WIDTH.
- `cnt_clr`=1 or `cpu_reset_req`=1 clears it to 0. Clear wins over a same-cycle increment.
- `stepvalue` is sampled only at the trigger edge; later changes do not affect a step in progress.

Reset values (`reset`=1):
- State RUN.
- `cpu_en`=0 during reset, 1 from the first cycle after.
- `cpu_reset`=0, `step_count`=0, `busy`=0, `step_done`=0, `bp_hit`=0, `remaining`=0.

## Timing
- All outputs are registered. "Cycle n" is the cycle in which an input is sampled.
- `debug_en` rises at n in RUN → `cpu_en`=0 from n+1.
- `debug_en` falls at n in HALT → `cpu_en`=1 from n+1.
- Step edge sampled at n in HALT → `cpu_en`=1 for cycles n+1 .. n+N, where N=`stepvalue`+1. `busy` is high for the same cycles. At n+N+1, `cpu_en`=0 and `step_done`=1.
- `step_count` reflects an enabled cycle one cycle later: its value at n+N+1 equals its value at n, plus N.
- `cpu_reset_req` rises at n → `cpu_reset`=1 and `cpu_en`=0 at n+1. `cpu_reset_req` falls at m → `cpu_reset`=0 at m+1, and `cpu_en` follows the destination state at m+1.
- Back-to-back steps: the earliest accepted edge is the cycle after `step_done`.

## Configuration
Macro `ARYA_DBG_BREAKPOINT_EN`.

Defined:
- The `bp_*` ports exist.
- In RUN, `bp_valid`=1 and `bp_pc`==`bp_addr` at n → HALT with `cpu_en`=0 at n+1, and `bp_hit`=1.
- `bp_hit` stays set until the state leaves HALT.
- The compare is not evaluated in STEP, so stepping off a breakpoint works.
- The breakpoint halts even when `debug_en`=0. HALT is held while the match persists, and the state returns to RUN only after `bp_valid` is deasserted or `bp_addr` changes.

Undefined:
- The `bp_*` ports are absent and there is no breakpoint logic.

## Test plan
- Release reset with all inputs 0, run 10 cycles → `cpu_en`=1 from cycle 1, `step_count`=10 at cycle 11.
- Set `debug_en`=1, then pulse `stepinto_en` with `stepvalue`=3 → `cpu_en` high exactly 4 cycles, `busy` high for those 4 cycles, `step_done` single pulse, `step_count` +4.
- Pulse `stepinto_en` with `stepvalue`=7 and drop `debug_en` after 2 enabled cycles → RUN, `cpu_en` stays 1, no `step_done`.
- Hold `stepinto_en`=1 through reset with `debug_en`=1 → no step; a later 0→1 transition steps 1 cycle when `stepvalue`=0.
- Assert `cpu_reset_req` mid-step, and also assert `cnt_clr` during a RUN cycle → `cpu_reset`=1 and `cpu_en`=0 next cycle, `step_count`=0; after release with `debug_en`=1, the state is HALT.
- With `ARYA_DBG_BREAKPOINT_EN`, drive `bp_addr`=0x1F and `bp_valid`=1 while `bp_pc` ramps → `cpu_en`=0 the cycle after `bp_pc`=0x1F, `bp_hit`=1; a following step clears `bp_hit`.
